apb_master_arbiter: RTL

//  Shares one APB master port among MASTER_COUNT requesters with round-robin arbitration.

---
 rtl/apb_master_arbiter_if.sv | 24 ++
 rtl/apb_master_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester handshake and shared APB port signals of the arbiter
interface apb_master_arbiter_if #(
    parameter int MASTER_COUNT = 3
);
    logic [MASTER_COUNT-1:0] req_i;
    logic [MASTER_COUNT-1:0] gnt_o;
    logic [MASTER_COUNT-1:0] done_o;
    logic                    pslverr_o;
    logic                    timeout_o;
    logic                    m_psel_o;
    logic                    m_penable_o;
    logic                    m_pready_i;
    logic                    m_pslverr_i;

    modport master (
        input  req_i, m_pready_i, m_pslverr_i,
        output gnt_o, done_o, pslverr_o, timeout_o, m_psel_o, m_penable_o
    );

    modport slave (
        output req_i, m_pready_i, m_pslverr_i,
        input  gnt_o, done_o, pslverr_o, timeout_o, m_psel_o, m_penable_o
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port; ACCESS timeout enabled by APB_ARB_TIMEOUT_EN
module apb_master_arbiter #(
    parameter int MASTER_COUNT   = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                  clk_i,
    input logic                  rst_i,
    apb_master_arbiter_if.master bus
);
    localparam int IW = $clog2(MASTER_COUNT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           pick_idx, gnt_idx, rr_next;
    logic [IW:0]             probe;
    logic                    pick_vld;
    logic                    expire;
    logic [MASTER_COUNT-1:0] gnt_q, gnt_d, done_q, done_d;
    logic                    pslverr_q, pslverr_d;
    logic                    psel_q, psel_d, penable_q, penable_d;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
`endif

    // Round-robin search: the active request at the smallest offset from rr_ptr wins
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        probe    = '0;
        for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
            probe = {1'b0, rr_ptr_q} + (IW+1)'(i);
            probe = (probe >= (IW+1)'(MASTER_COUNT)) ? probe - (IW+1)'(MASTER_COUNT) : probe;
            if (bus.req_i[probe[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = probe[IW-1:0];
            end
        end
    end

    // Encode the held one-hot grant and derive the pointer just past it
    always_comb begin
        gnt_idx = '0;
        for (int j = 0; j < MASTER_COUNT; j++)
            if (gnt_q[j]) gnt_idx = IW'(j);
        rr_next = (gnt_idx == IW'(MASTER_COUNT - 1)) ? '0 : gnt_idx + IW'(1);
    end

    // FSM next state and registered outputs; completion clears the bus and advances rr_ptr
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        pslverr_d = 1'b0;
        psel_d    = psel_q;
        penable_d = penable_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        expire    = !bus.m_pready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        timeout_d = (state_q == ACCESS) && expire;
`else
        expire    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = MASTER_COUNT'(1) << pick_idx;
                    psel_d  = 1'b1;
                    state_d = SETUP;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.m_pready_i || expire) begin
                    done_d    = gnt_q;
                    pslverr_d = expire ? 1'b1 : bus.m_pslverr_i;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    gnt_d     = '0;
                    rr_ptr_d  = rr_next;
                    state_d   = IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else cnt_d = cnt_q + CW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            pslverr_q <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            pslverr_q <= pslverr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.pslverr_o   = pslverr_q;
    assign bus.m_psel_o    = psel_q;
    assign bus.m_penable_o = penable_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign bus.timeout_o   = timeout_q;
`else
    assign bus.timeout_o   = 1'b0;
`endif
endmodule
